// File: rtl/hdr_strip_pkg.sv
// Shared widths, FSM encodings and the status-word layout for the header-strip receiver.
package hdr_strip_pkg;

    localparam int LEN_W  = 8;
    localparam int WCNT_W = 9;
    localparam int MSG_W  = 10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PAY  = 2'd1,
        W_DISC = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } rd_state_t;

    // Status word: {err, byte count}
    function automatic logic [MSG_W-1:0] pack_msg(input logic err, input logic [WCNT_W-1:0] cnt);
        return {err, cnt};
    endfunction

endpackage

// File: rtl/hdr_strip_rx_sync_fifo.sv
// Single-clock show-ahead FIFO: q holds the head entry whenever empty is low.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             q,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   usedw
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_ok;
    logic          rd_ok;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign usedw = count;
    assign q     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hdr_strip_rx.sv
// Length-header receiver: strips the LEN byte, buffers the payload and forwards
// only packets whose eop lands exactly on byte LEN.
module hdr_strip_rx
    import hdr_strip_pkg::*;
#(
    parameter int DATA_DEPTH = 512,
    parameter int MSG_DEPTH  = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_vld,
    input  logic             din_sop,
    input  logic             din_eop,
    output logic [7:0]       dout,
    output logic             dout_vld,
    output logic             dout_sop,
    output logic             dout_eop,
    output logic             pkt_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int MAW = $clog2(MSG_DEPTH);

    wr_state_t           w_state, w_state_nxt;
    logic [WCNT_W-1:0]   wcnt, wcnt_nxt, wcnt_inc;
    logic [LEN_W-1:0]    len, len_nxt;
    logic                data_wr, msg_push, drop_inc, abort, msg_short;
    logic [MSG_W-1:0]    msg_wdata;

    rd_state_t           r_state, r_state_nxt;
    logic                msg_pop, data_pop, r_err, r_last;
    logic [WCNT_W-1:0]   r_cnt, rcnt;

    logic [7:0]          data_q;
    logic                data_empty, data_full;
    logic [DAW:0]        data_usedw, data_free;
    logic [MSG_W-1:0]    msg_q;
    logic                msg_empty, msg_full;
    logic [MAW:0]        msg_usedw;

    sync_fifo #(.W(8), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk(clk), .rst_n(rst_n), .wr_en(data_wr), .wr_data(din), .rd_en(data_pop),
        .q(data_q), .empty(data_empty), .full(data_full), .usedw(data_usedw)
    );

    sync_fifo #(.W(MSG_W), .DEPTH(MSG_DEPTH)) u_msg_fifo (
        .clk(clk), .rst_n(rst_n), .wr_en(msg_push), .wr_data(msg_wdata), .rd_en(msg_pop),
        .q(msg_q), .empty(msg_empty), .full(msg_full), .usedw(msg_usedw)
    );

    assign wcnt_inc  = wcnt + WCNT_W'(1);
    assign data_free = (DAW+1)'(DATA_DEPTH) - data_usedw;
    assign abort     = din_vld && din_sop && (w_state == W_PAY);
    // An abort consumes one msg slot this clk, so the new header needs a second one.
    assign msg_short = abort ? (msg_usedw >= (MAW+1)'(MSG_DEPTH - 1)) : msg_full;

    always_comb begin
        w_state_nxt = w_state;
        wcnt_nxt    = wcnt;
        len_nxt     = len;
        data_wr     = 1'b0;
        msg_push    = 1'b0;
        msg_wdata   = '0;
        drop_inc    = 1'b0;
        if (din_vld) begin
            if (din_sop) begin
                if (abort) begin
                    msg_push  = 1'b1;
                    msg_wdata = pack_msg(1'b1, wcnt);
                end
                if (din_eop || din == '0) begin
                    if (!abort) begin
                        msg_push  = 1'b1;
                        msg_wdata = pack_msg(1'b1, '0);
                    end
                    w_state_nxt = W_IDLE;
                end else if (msg_short || data_free < (DAW+1)'(din)) begin
                    drop_inc    = 1'b1;
                    w_state_nxt = W_DISC;
                end else begin
                    wcnt_nxt    = '0;
                    len_nxt     = din;
                    w_state_nxt = W_PAY;
                end
            end else begin
                case (w_state)
                    W_PAY: begin
                        data_wr  = !data_full;
                        wcnt_nxt = wcnt_inc;
                        if (wcnt_inc == WCNT_W'(len)) begin
                            msg_push    = 1'b1;
                            msg_wdata   = pack_msg(!din_eop, WCNT_W'(len));
                            w_state_nxt = din_eop ? W_IDLE : W_DISC;
                        end else if (din_eop) begin
                            msg_push    = 1'b1;
                            msg_wdata   = pack_msg(1'b1, wcnt_inc);
                            w_state_nxt = W_IDLE;
                        end
                    end
                    W_DISC:  if (din_eop) w_state_nxt = W_IDLE;
                    default: w_state_nxt = w_state;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state  <= W_IDLE;
            wcnt     <= '0;
            len      <= '0;
            drop_cnt <= '0;
        end else begin
            w_state <= w_state_nxt;
            wcnt    <= wcnt_nxt;
            len     <= len_nxt;
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    assign r_last = (rcnt == r_cnt - WCNT_W'(1));

    always_comb begin
        r_state_nxt = r_state;
        msg_pop     = 1'b0;
        data_pop    = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (!msg_empty) begin
                    msg_pop = 1'b1;
                    if (msg_q[WCNT_W-1:0] != '0) r_state_nxt = R_RUN;
                end
            end
            R_RUN: begin
                data_pop = !data_empty;
                if (r_last) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            rcnt     <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            pkt_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            r_state  <= r_state_nxt;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            pkt_err  <= 1'b0;
            if (msg_pop) begin
                r_err <= msg_q[MSG_W-1];
                r_cnt <= msg_q[WCNT_W-1:0];
                rcnt  <= '0;
                if (msg_q[MSG_W-1]) begin
                    pkt_err <= 1'b1;
                    if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                end
            end
            // Failed packets are still drained byte by byte, just never marked valid.
            if (r_state == R_RUN) begin
                dout     <= data_q;
                dout_vld <= !r_err;
                dout_sop <= !r_err && (rcnt == '0);
                dout_eop <= !r_err && r_last;
                rcnt     <= rcnt + WCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hdr_strip_rx.sv
// Bench for hdr_strip_rx: packet table plus hand sequences, output beats checked
// against an expected queue filled while stimulus is driven.
module tb_hdr_strip_rx;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       din = '0;
    logic             din_vld = 1'b0;
    logic             din_sop = 1'b0;
    logic             din_eop = 1'b0;
    logic [7:0]       dout;
    logic             dout_vld, dout_sop, dout_eop, pkt_err;
    logic [CNT_W-1:0] err_cnt, drop_cnt;

    always #5 clk = ~clk;

    hdr_strip_rx #(.DATA_DEPTH(512), .MSG_DEPTH(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .pkt_err(pkt_err), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [7:0] hdr;
        logic [8:0] n;
        logic       eop;
        logic       good;
    } vec_t;

    vec_t        tbl [17];
    logic [9:0]  exp_q [$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          exp_err = 0;
    int          exp_drop = 0;
    int          err_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n) begin
            if (pkt_err) err_pulses++;
            if (dout_vld) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", {dout, dout_sop, dout_eop});
                end else begin
                    e = exp_q.pop_front();
                    check("dout_beat", {22'b0, dout, dout_sop, dout_eop}, {22'b0, e});
                end
            end else if (dout_sop || dout_eop) begin
                n_vec++;
                n_fail++;
                $display("FAIL stray_flags: got sop=%0b eop=%0b expected 0", dout_sop, dout_eop);
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        din = d; din_vld = 1'b1; din_sop = s; din_eop = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_vld = 1'b0;
            din_sop = 1'($urandom_range(0, 1));
            din_eop = 1'($urandom_range(0, 1));
            din     = 8'($urandom);
        end
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input int n, input logic eop,
                            input logic good, input int gap);
        logic [7:0] b;
        beat(hdr, 1'b1, (n == 0) && eop);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            beat(b, 1'b0, eop && (i == n - 1));
            if (good) exp_q.push_back({b, i == 0, i == n - 1});
        end
        if (!good) exp_err++;
        idle(gap);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (8) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, {24'b0, dout}, 0);
        check({tag, "_vld"}, {31'b0, dout_vld}, 0);
        check({tag, "_sop"}, {31'b0, dout_sop}, 0);
        check({tag, "_eop"}, {31'b0, dout_eop}, 0);
        check({tag, "_pkt_err"}, {31'b0, pkt_err}, 0);
        check({tag, "_err_cnt"}, {16'b0, err_cnt}, 0);
        check({tag, "_drop_cnt"}, {16'b0, drop_cnt}, 0);
    endtask

    initial begin
        logic [7:0] h;
        int         n;
        logic       e;

        tbl = '{
            '{8'd3,  9'd3,  1'b1, 1'b1},
            '{8'd4,  9'd2,  1'b1, 1'b0},   // short, eop early
            '{8'd6,  9'd6,  1'b1, 1'b1},
            '{8'd2,  9'd3,  1'b1, 1'b0},   // long
            '{8'd1,  9'd1,  1'b1, 1'b1},
            '{8'd5,  9'd2,  1'b0, 1'b0},   // cut off by next sop
            '{8'd1,  9'd1,  1'b1, 1'b1},
            '{8'd0,  9'd0,  1'b1, 1'b0},   // sop&eop header
            '{8'd7,  9'd7,  1'b1, 1'b1},
            '{8'd0,  9'd2,  1'b1, 1'b0},   // LEN 0, payload ignored
            '{8'd3,  9'd3,  1'b0, 1'b0},   // LEN reached, no eop
            '{8'd16, 9'd16, 1'b1, 1'b1},
            '{8'd4,  9'd0,  1'b0, 1'b0},   // header only
            '{8'd2,  9'd1,  1'b0, 1'b0},
            '{8'd3,  9'd3,  1'b1, 1'b1},
            '{8'd1,  9'd2,  1'b1, 1'b0},
            '{8'd2,  9'd2,  1'b1, 1'b1}
        };

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        foreach (tbl[i])
            send_pkt(tbl[i].hdr, int'(tbl[i].n), tbl[i].eop, tbl[i].good, $urandom_range(0, 2));

        // Non-sop valid beat while idle must be ignored
        send_pkt(8'd2, 2, 1'b1, 1'b1, 0);
        beat(8'h5A, 1'b0, 1'b1);
        idle(1);
        send_pkt(8'd1, 1, 1'b1, 1'b1, 1);

        for (int i = 0; i < 24; i++) begin
            h = 8'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) begin
                n = int'(h);
                e = 1'b1;
            end else begin
                n = $urandom_range(1, int'(h) + 2);
                e = 1'($urandom_range(0, 1));
            end
            send_pkt(h, n, e, e && (n == int'(h)), $urandom_range(0, 3));
        end
        send_pkt(8'd2, 2, 1'b1, 1'b1, 1);
        wait_drain(3000);
        check("err_cnt_table", {16'b0, err_cnt}, exp_err);
        check("pkt_err_pulses", err_pulses, exp_err);
        check("drop_cnt_table", {16'b0, drop_cnt}, 0);

        // Zero-length packet, then a 255-byte packet that stalls the read side
        // while 16 short packets fill the status FIFO; the 17th is refused.
        send_pkt(8'd0, 0, 1'b1, 1'b0, 0);
        send_pkt(8'd255, 255, 1'b1, 1'b1, 0);
        for (int i = 0; i < 16; i++) send_pkt(8'd1, 1, 1'b1, 1'b1, 0);
        beat(8'd1, 1'b1, 1'b0);
        beat(8'hEE, 1'b0, 1'b1);
        exp_drop++;
        idle(2);
        check("drop_cnt_full", {16'b0, drop_cnt}, exp_drop);
        wait_drain(2000);
        check("err_cnt_long", {16'b0, err_cnt}, exp_err);
        check("drop_cnt_long", {16'b0, drop_cnt}, exp_drop);

        // Reset in the middle of a packet
        beat(8'd5, 1'b1, 1'b0);
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h02, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        din_vld = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        exp_err = 0;
        exp_drop = 0;
        err_pulses = 0;
        rst_n = 1'b1;
        idle(2);
        send_pkt(8'd2, 2, 1'b1, 1'b1, 2);
        wait_drain(200);
        check("err_cnt_after_rst", {16'b0, err_cnt}, 0);
        check("pkt_err_after_rst", err_pulses, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
